// File: rtl/fifo_read_adapter.sv
// fifo_read_adapter
// Turns a one-cycle-latency synchronous FIFO read port into a valid/ready
// stream. A 2-entry skid buffer plus one in-flight read keeps the stream at
// one word per cycle while still honouring downstream back-pressure.
module fifo_read_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty_flag,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic [1:0][DATA_WIDTH-1:0] buf_q;
  logic                       head;
  logic                       tail;
  logic [1:0]                 count;
  logic                       inflight;
  logic                       pop;
  logic [2:0]                 occ;

  // Occupancy after this cycle's pop, counting the read already on its way.
  // A pop needs count>=1, so this never underflows; it never exceeds 2.
  assign pop = m_valid & m_ready;
  assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  // Issue a read only when the word will have a slot when it lands.
  assign fifo_read_en = ~reset & ~fifo_empty_flag & (occ < 3'd2);

  // Stream outputs come straight from registers.
  assign m_valid = (count != 2'd0);
  assign m_data  = buf_q[head];

  // Buffer, pointers, in-flight tracking and handshake counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q     <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      inflight  <= 1'b0;
      words_out <= '0;
    end else begin
      inflight <= fifo_read_en;
      count    <= occ[1:0];
      if (inflight) begin
        buf_q[tail] <= fifo_data_out;
        tail        <= ~tail;
      end
      if (pop) begin
        head      <= ~head;
        words_out <= words_out + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter: behavioural upstream FIFO (a queue with one
// cycle read latency), expected-word scoreboard and an independent monitor.
module tb_fifo_read_adapter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty_flag = 1'b1;
  logic [7:0]  fifo_data_out = 8'h00;
  logic        m_ready = 1'b0;
  logic        fifo_read_en, m_valid;
  logic [7:0]  m_data;
  logic [15:0] words_out;
  logic        rd4, v4;
  logic [7:0]  d4;
  logic [3:0]  w4;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int vecs = 0;
  int errs = 0;
  int hs_cnt = 0;
  int n_reads = 0;
  int n_pops = 0;

  always #5 clk = ~clk;

  fifo_read_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .fifo_empty_flag(fifo_empty_flag),
    .fifo_data_out(fifo_data_out), .fifo_read_en(fifo_read_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .words_out(words_out)
  );

  fifo_read_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .fifo_empty_flag(fifo_empty_flag),
    .fifo_data_out(fifo_data_out), .fifo_read_en(rd4),
    .m_valid(v4), .m_ready(m_ready), .m_data(d4), .words_out(w4)
  );

  task automatic chk(input string name, input int act, input int expv);
    vecs++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: drive at the falling edge, sample after settling, then model
  // the FIFO returning the read word one cycle after read_en.
  task automatic step(input logic rdy);
    logic rd;
    @(negedge clk);
    m_ready = rdy;
    fifo_empty_flag = (fq.size() == 0);
    #1;
    rd = fifo_read_en;
    chk("read_while_empty", int'(rd & fifo_empty_flag), 0);
    if (rd4 != rd) chk("narrow_inst_read_en", int'(rd4), int'(rd));
    if (rd) n_reads++;
    if (m_valid && m_ready) n_pops++;
    @(posedge clk);
    #1;
    if (rd && fq.size() != 0) fifo_data_out = fq.pop_front();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    fq.delete();
    exp_q.delete();
    fifo_empty_flag = 1'b1;
    fifo_data_out = 8'h00;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    fifo_empty_flag = 1'b0;
    #1;
    chk("rst_read_en_forced_low", int'(fifo_read_en), 0);
    fifo_empty_flag = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_words_out", int'(words_out), 0);
    chk("rst_read_en", int'(fifo_read_en), 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and tracks the count.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        hs_cnt = 0;
      end else begin
        chk("words_out", int'(words_out), hs_cnt % 65536);
        chk("words_out_cnt4", int'(w4), hs_cnt % 16);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("m_data_order", int'(m_data), int'(e));
          end
          hs_cnt++;
        end
      end
    end
  end

  initial begin : main
    int pushed;
    int guard;
    logic [7:0] first;

    // Three words, ready high: first word two edges after empty falls.
    do_reset();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    step(1'b1);
    chk("lat_edge1_not_valid", int'(m_valid), 0);
    step(1'b1);
    chk("lat_edge2_valid", int'(m_valid), 1);
    chk("lat_edge2_data", int'(m_data), 8'h11);
    n_pops = 0;
    repeat (3) step(1'b1);
    chk("three_consecutive_pops", n_pops, 3);
    repeat (2) step(1'b1);
    chk("words_out_3", int'(words_out), 3);
    chk("scoreboard_empty_1", exp_q.size(), 0);

    // Back-pressure: only two reads may be outstanding/held.
    do_reset();
    push_word(8'h5A); push_word(8'hC3); push_word(8'h7E);
    n_reads = 0;
    repeat (10) step(1'b0);
    chk("stall_reads", n_reads, 2);
    chk("stall_valid", int'(m_valid), 1);
    chk("stall_data_held", int'(m_data), 8'h5A);
    repeat (6) step(1'b1);
    chk("stall_drain_count", int'(words_out), 3);
    chk("scoreboard_empty_2", exp_q.size(), 0);

    // Throughput: continuous supply, ready high.
    do_reset();
    for (int i = 0; i < 25; i++) push_word(8'(i * 7 + 3));
    repeat (2) step(1'b1);
    n_pops = 0;
    repeat (20) step(1'b1);
    chk("throughput_20", n_pops, 20);

    // Random words, random ready.
    do_reset();
    pushed = 0;
    guard = 0;
    while (pushed < 100 && guard < 2000) begin
      if ($urandom_range(0, 1) == 1) begin
        push_word(8'($urandom));
        pushed++;
      end
      step(1'($urandom_range(0, 1)));
      guard++;
    end
    guard = 0;
    while ((exp_q.size() != 0 || m_valid) && guard < 2000) begin
      step(1'($urandom_range(0, 1)));
      guard++;
    end
    chk("random_drain_done", int'(guard < 2000), 1);
    chk("random_pushed", pushed, 100);
    step(1'b0);
    chk("random_words_out", int'(words_out), 100);

    // Counter wrap on the narrow instance.
    do_reset();
    for (int i = 0; i < 17; i++) push_word(8'(8'hF0 ^ i));
    repeat (25) step(1'b1);
    chk("wrap_words_out_16", int'(words_out), 17);
    chk("wrap_words_out_4", int'(w4), 1);

    // Reset in the middle of streaming, with a read outstanding.
    do_reset();
    for (int i = 0; i < 6; i++) push_word(8'(8'h40 + i));
    repeat (4) step(1'b1);
    first = 8'h00;
    #2;
    fifo_empty_flag = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_words_out", int'(words_out), 0);
    chk("midrst_read_en", int'(fifo_read_en), 0);
    fq.delete();
    exp_q.delete();
    fifo_empty_flag = 1'b1;
    fifo_data_out = 8'h00;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_word(8'hA5);
    step(1'b0);
    step(1'b0);
    first = m_data;
    chk("post_rst_valid", int'(m_valid), 1);
    chk("post_rst_first_word", int'(first), 8'hA5);
    repeat (2) step(1'b1);
    chk("post_rst_words_out", int'(words_out), 1);
    chk("post_rst_empty_after", int'(m_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
